// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, register enables and forward selects out.
// The performance counter outputs exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic       id_uses_rt, jump_id, ex_memread, mem_regwrite, wb_regwrite;
  logic       pcsrc_mem, dmem_req, dmem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write;
  logic       ex_mem_flush, ex_mem_write, mem_wb_write, mem_error;
  logic [1:0] fwd_a, fwd_b, ctrl_state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rt, jump_id, ex_rs, ex_rt, ex_memread, ex_dest,
           mem_dest, mem_regwrite, wb_dest, wb_regwrite, pcsrc_mem, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write, ex_mem_flush,
           ex_mem_write, mem_wb_write, fwd_a, fwd_b, mem_error, ctrl_state,
           stall_cycles, flush_events
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, jump_id, ex_rs, ex_rt, ex_memread, ex_dest,
           mem_dest, mem_regwrite, wb_dest, wb_regwrite, pcsrc_mem, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write, ex_mem_flush,
           ex_mem_write, mem_wb_write, fwd_a, fwd_b, mem_error, ctrl_state,
           stall_cycles, flush_events
  );
`else
  modport master (
    output id_rs, id_rt, id_uses_rt, jump_id, ex_rs, ex_rt, ex_memread, ex_dest,
           mem_dest, mem_regwrite, wb_dest, wb_regwrite, pcsrc_mem, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write, ex_mem_flush,
           ex_mem_write, mem_wb_write, fwd_a, fwd_b, mem_error, ctrl_state
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, jump_id, ex_rs, ex_rt, ex_memread, ex_dest,
           mem_dest, mem_regwrite, wb_dest, wb_regwrite, pcsrc_mem, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write, ex_mem_flush,
           ex_mem_write, mem_wb_write, fwd_a, fwd_b, mem_error, ctrl_state
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage MIPS pipeline: stalls, flushes,
// bubbles, ALU forwarding and data-memory wait sequencing with a timeout.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERROR = 2'b10} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic               mem_error, mem_error_nxt;
  logic               mem_stall, load_use;

  assign mem_stall = bus.dmem_req && !bus.dmem_ready;
  // $0 is hardwired zero, so a load into it can never create a dependency.
  assign load_use  = bus.ex_memread && (bus.ex_dest != 5'd0) &&
                     ((bus.ex_dest == bus.id_rs) ||
                      (bus.id_uses_rt && (bus.ex_dest == bus.id_rt)));

  // State register with the wait counter and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_error <= mem_error_nxt;
    end
  end

  // Next-state: enter wait on an unready access, leave on ready, trap on timeout.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    mem_error_nxt = mem_error;
    case (state)
      RUN: if (mem_stall) begin
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = CNT_W'(1);
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_nxt     = ERROR;
          mem_error_nxt = 1'b1;
        end else if (wait_cnt != {CNT_W{1'b1}}) begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase
  end

  // Register enables by hazard priority: wait > branch > load-use > jump.
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.id_ex_write  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.ex_mem_write = 1'b0;
    bus.mem_wb_write = 1'b0;
    if (!rst) begin
      case (state)
        RUN: if (!mem_stall) begin
          bus.pc_write     = 1'b1;
          bus.if_id_write  = 1'b1;
          bus.id_ex_write  = 1'b1;
          bus.ex_mem_write = 1'b1;
          bus.mem_wb_write = 1'b1;
          if (bus.pcsrc_mem) begin
            // Taken branch squashes the three younger instructions.
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
            bus.ex_mem_flush = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into EXE.
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
          end else if (bus.jump_id) begin
            bus.if_id_flush  = 1'b1;
          end
        end
        MEM_WAIT: if (bus.dmem_ready) begin
          bus.pc_write     = 1'b1;
          bus.if_id_write  = 1'b1;
          bus.id_ex_write  = 1'b1;
          bus.ex_mem_write = 1'b1;
          bus.mem_wb_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (bus.mem_regwrite && bus.mem_dest != 5'd0 && bus.mem_dest == src)    return 2'b10;
    else if (bus.wb_regwrite && bus.wb_dest != 5'd0 && bus.wb_dest == src) return 2'b01;
    else                                                                    return 2'b00;
  endfunction

  // Operand forwarding, youngest producer (EX/MEM) first; quiet during reset.
  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
    if (!rst) begin
      bus.fwd_a = fwd_sel(bus.ex_rs);
      bus.fwd_b = fwd_sel(bus.ex_rt);
    end
  end

  assign bus.mem_error  = mem_error;
  assign bus.ctrl_state = state;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;

  // Saturating counters of lost fetch cycles and squash events.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!bus.pc_write && state != ERROR && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if ((bus.if_id_flush || bus.id_ex_bubble || bus.ex_mem_flush) &&
          flush_events != 32'hFFFF_FFFF)
        flush_events <= flush_events + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_events = flush_events;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (built with MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  // Enable vector order: pc, if_id_w, if_id_flush, id_ex_bubble, id_ex_w,
  // ex_mem_flush, ex_mem_w, mem_wb_w.
  localparam logic [7:0] C_OFF  = 8'b0000_0000;
  localparam logic [7:0] C_RUN  = 8'b1100_1011;
  localparam logic [7:0] C_BR   = 8'b1111_1111;
  localparam logic [7:0] C_LU   = 8'b0001_1011;
  localparam logic [7:0] C_JMP  = 8'b1110_1011;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clr();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0; bus.jump_id = 1'b0;
    bus.ex_rs = 5'd0; bus.ex_rt = 5'd0; bus.ex_memread = 1'b0; bus.ex_dest = 5'd0;
    bus.mem_dest = 5'd0; bus.mem_regwrite = 1'b0; bus.wb_dest = 5'd0; bus.wb_regwrite = 1'b0;
    bus.pcsrc_mem = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  // Push the expectation for the inputs just driven, sample mid-cycle, then advance.
  task automatic step(input string tag, input logic [7:0] c, input logic [1:0] fa,
                      input logic [1:0] fb, input logic me, input logic [1:0] st);
    logic [14:0] e, o;
    string t;
    exp_q.push_back({c, fa, fb, me, st});
    tag_q.push_back(tag);
    @(negedge clk);
    o = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble, bus.id_ex_write,
         bus.ex_mem_flush, bus.ex_mem_write, bus.mem_wb_write, bus.fwd_a, bus.fwd_b,
         bus.mem_error, bus.ctrl_state};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    // Reset gates forwarding even with a matching producer.
    bus.mem_regwrite = 1'b1; bus.mem_dest = 5'd5; bus.ex_rs = 5'd5;
    step("rst_hold1", C_OFF, 2'b00, 2'b00, 1'b0, 2'b00);
    step("rst_hold2", C_OFF, 2'b00, 2'b00, 1'b0, 2'b00);
    clr(); rst = 1'b0;
    step("run_idle", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);

    // Load-use on rs, then the bubble has moved on.
    bus.ex_memread = 1'b1; bus.ex_dest = 5'd8; bus.id_rs = 5'd8;
    step("lu_rs", C_LU, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.ex_memread = 1'b0; bus.ex_dest = 5'd0;
    step("lu_after", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.ex_memread = 1'b1; bus.ex_dest = 5'd0; bus.id_rs = 5'd0;
    step("lu_r0", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.ex_dest = 5'd9; bus.id_rs = 5'd3; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1;
    step("lu_rt", C_LU, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.id_uses_rt = 1'b0;
    step("lu_rt_unused", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);
    clr();

    // Forwarding priority and $0 exclusion.
    bus.mem_regwrite = 1'b1; bus.mem_dest = 5'd5; bus.wb_regwrite = 1'b1; bus.wb_dest = 5'd5;
    bus.ex_rs = 5'd5; bus.ex_rt = 5'd6;
    step("fwd_exmem", C_RUN, 2'b10, 2'b00, 1'b0, 2'b00);
    bus.ex_rt = 5'd5; bus.mem_regwrite = 1'b0;
    step("fwd_memwb", C_RUN, 2'b01, 2'b01, 1'b0, 2'b00);
    bus.mem_regwrite = 1'b1; bus.mem_dest = 5'd0; bus.wb_dest = 5'd0;
    bus.ex_rs = 5'd0; bus.ex_rt = 5'd0;
    step("fwd_r0", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);
    clr();

    // Branch beats load-use; jump yields to load-use.
    bus.pcsrc_mem = 1'b1; bus.ex_memread = 1'b1; bus.ex_dest = 5'd8; bus.id_rs = 5'd8;
    step("br_over_lu", C_BR, 2'b00, 2'b00, 1'b0, 2'b00);
    clr();
    step("br_after", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.jump_id = 1'b1;
    step("jump", C_JMP, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.ex_memread = 1'b1; bus.ex_dest = 5'd4; bus.id_rs = 5'd4;
    step("lu_over_jump", C_LU, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.ex_memread = 1'b0; bus.ex_dest = 5'd0;
    step("jump_again", C_JMP, 2'b00, 2'b00, 1'b0, 2'b00);
    clr();

    // Memory wait of three cycles, then release.
    bus.dmem_req = 1'b1;
    step("wait_enter", C_OFF, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.mem_regwrite = 1'b1; bus.mem_dest = 5'd7; bus.ex_rs = 5'd7;
    step("wait_1_fwd", C_OFF, 2'b10, 2'b00, 1'b0, 2'b01);
    bus.mem_regwrite = 1'b0; bus.mem_dest = 5'd0; bus.ex_rs = 5'd0; bus.pcsrc_mem = 1'b1;
    step("wait_2_br", C_OFF, 2'b00, 2'b00, 1'b0, 2'b01);
    bus.pcsrc_mem = 1'b0; bus.dmem_ready = 1'b1;
    step("wait_release", C_RUN, 2'b00, 2'b00, 1'b0, 2'b01);
    clr();
    step("wait_done", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b1;
    step("req_ready", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);

    // Timeout: four wait cycles, then ERROR until reset.
    bus.dmem_ready = 1'b0;
    step("to_enter", C_OFF, 2'b00, 2'b00, 1'b0, 2'b00);
    for (int i = 1; i <= 4; i++)
      step($sformatf("to_wait%0d", i), C_OFF, 2'b00, 2'b00, 1'b0, 2'b01);
    step("to_error", C_OFF, 2'b00, 2'b00, 1'b1, 2'b10);
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1; bus.pcsrc_mem = 1'b1;
    step("err_hold", C_OFF, 2'b00, 2'b00, 1'b1, 2'b10);
    rst = 1'b1;
    step("err_rst", C_OFF, 2'b00, 2'b00, 1'b1, 2'b10);
    rst = 1'b0; clr();
    step("err_cleared", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);

    // Reset in the middle of a wait.
    bus.dmem_req = 1'b1;
    step("mw_enter", C_OFF, 2'b00, 2'b00, 1'b0, 2'b00);
    step("mw_in", C_OFF, 2'b00, 2'b00, 1'b0, 2'b01);
    rst = 1'b1;
    step("mw_rst", C_OFF, 2'b00, 2'b00, 1'b0, 2'b01);
    rst = 1'b0; clr();
    step("mw_clear", C_RUN, 2'b00, 2'b00, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage MIPS pipeline (IF/ID/EXE/MEM/WB).
- Produces stall, flush and bubble enables for the PC and the four pipeline registers.
- Produces forwarding selects for the EXE-stage ALU operands.
- Sequences data-memory wait states through a small FSM, with a timeout watchdog.
- Sits beside the datapath in `main`; all datapath register enables come from this block.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before mem_error is set (range 1..255).
- CNT_W, 8, width of the wait-cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  Rs address of the instruction in ID
- id_rt  in  5  Rt address of the instruction in ID
- id_uses_rt  in  1  ID instruction reads Rt (R-type, beq, sw)
- jump_id  in  1  Jump decoded in ID
- ex_rs  in  5  Rs address held in the ID/EX register
- ex_rt  in  5  Rt address held in the ID/EX register
- ex_memread  in  1  MemRead_reg_ID (load in EXE)
- ex_dest  in  5  Destination_EXE
- mem_dest  in  5  Destination_out_MEM
- mem_regwrite  in  1  regWriteOut_MEM
- wb_dest  in  5  Destination_out_WB
- wb_regwrite  in  1  regWriteOut_WB
- pcsrc_mem  in  1  PCsrc_MEM (branch taken, resolved in MEM)
- dmem_req  in  1  MEM stage is issuing a read or write
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clears to NOP
- id_ex_bubble  out  1  ID/EX loads zero control bits
- id_ex_write  out  1  ID/EX load enable
- ex_mem_flush  out  1  EX/MEM clears control bits
- ex_mem_write  out  1  EX/MEM load enable
- mem_wb_write  out  1  MEM/WB load enable
- fwd_a  out  2  ALU A-operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  ALU B-operand select, same encoding as fwd_a
- mem_error  out  1  sticky memory-timeout flag
- ctrl_state  out  2  current FSM state: 00 RUN, 01 MEM_WAIT, 10 ERROR

Behaviour:
- Reset: state=RUN, wait_cnt=0, mem_error=0. While rst=1, every enable and flush output is 0 and fwd_a/fwd_b=00.
- Outputs are combinational from the registered state plus current inputs. State, wait_cnt and mem_error change only on the clock edge.
- Hazard priority, highest first: ERROR > MEM_WAIT/entering wait > pcsrc_mem > load-use > jump_id.
- RUN, no hazard: all *_write=1, all flush/bubble=0.
- Memory wait: in RUN with dmem_req=1 and dmem_ready=0:
  - all *_write=0 this cycle; next state MEM_WAIT; wait_cnt<=1.
  - In MEM_WAIT, all *_write=0 and flushes=0.
  - dmem_ready=1: release this cycle with all writes=1; next state RUN; wait_cnt<=0.
  - Otherwise wait_cnt increments. When wait_cnt==MEM_TIMEOUT and still not ready: next state ERROR, mem_error<=1.
- ERROR: all writes 0 and flushes 0 until rst. mem_error stays 1.
- Branch taken (pcsrc_mem=1, no memory wait): if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1; pc_write=1 (loads branch target); one cycle only.
- Load-use (ex_memread=1, ex_dest!=0, and ex_dest==id_rs or (id_uses_rt and ex_dest==id_rt)):
  - pc_write=0, if_id_write=0, id_ex_bubble=1; one bubble only.
  - The next cycle re-evaluates with the updated pipeline.
- Jump (jump_id=1, no higher-priority hazard): if_id_flush=1, pc_write=1.
- Load-use and jump together: load-use wins; jump is seen again next cycle.
- Forwarding (evaluated in every state):
  - fwd_a=10 if mem_regwrite, mem_dest!=0, mem_dest==ex_rs.
  - else fwd_a=01 if wb_regwrite, wb_dest!=0, wb_dest==ex_rs.
  - else 00. fwd_b uses the same rule with ex_rt.
  - EX/MEM beats MEM/WB when both match.
- Register $0 never causes a stall or a forward.
- rst asserted mid-wait returns the block to RUN on the next edge and clears wait_cnt and mem_error.
- wait_cnt saturates at its maximum; it never wraps.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both cleared by rst.
  - stall_cycles increments each cycle pc_write=0 outside ERROR.
  - flush_events increments each cycle any flush or bubble is 1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Hold rst=1 for 2 cycles → all enables 0, fwd_a/fwd_b=00, ctrl_state=00. Release rst → pc_write=1, all writes 1.
- ex_memread=1, ex_dest=8, id_rs=8 → exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_dest=0 → no stall.
- mem_regwrite=1, mem_dest=5, wb_regwrite=1, wb_dest=5, ex_rs=5, ex_rt=6 → fwd_a=10, fwd_b=00. Set ex_rt=5 and mem_regwrite=0 → fwd_b=01.
- pcsrc_mem=1 in the same cycle as a load-use condition → if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1 for one cycle.
- dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 → all writes 0 for 3 cycles, ctrl_state=01, then writes=1 and ctrl_state=00.
- dmem_ready held 0 with MEM_TIMEOUT=4 → ctrl_state=10 and mem_error=1 after the 4th wait cycle. Stays set until rst, which clears it.
